// File: rtl/ctrl_pkg.sv
// Shared encodings for the hardwired datapath controller: opcodes, ALU codes,
// FSM states, instruction classes and the bundle of datapath control lines.
package ctrl_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_ADD = 5'b00011;
    localparam logic [4:0] ALU_SUB = 5'b00100;
    localparam logic [4:0] ALU_AND = 5'b00101;
    localparam logic [4:0] ALU_OR  = 5'b00110;

    typedef enum logic [3:0] {
        ST_RST, ST_F0, ST_F1, ST_F2, ST_E3, ST_E4, ST_E5, ST_E6, ST_E7, ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        CL_MEM_LD, CL_MEM_LDI, CL_MEM_ST, CL_ALU_R, CL_ALU_I, CL_NOP, CL_HALT, CL_ILL
    } iclass_t;

    // One bit per datapath control line, in the order of the top-level ports.
    typedef struct packed {
        logic pc_out;
        logic pc_in;
        logic inc_pc;
        logic mar_in;
        logic mdr_in;
        logic mdr_out;
        logic read;
        logic ir_in;
        logic y_in;
        logic zlo_in;
        logic zlo_out;
        logic gra;
        logic grb;
        logic grc;
        logic r_in;
        logic r_out;
        logic ba_out;
        logic c_out;
        logic ram_write;
    } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: instruction class plus the ALU operation the
// execute step E4 must request.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [4:0] opcode,
    output iclass_t    iclass,
    output logic [4:0] alu_op
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a value held over, which would otherwise infer a latch.
        iclass = CL_ILL;
        alu_op = ALU_ADD;
        case (opcode)
            OP_LD:   iclass = CL_MEM_LD;
            OP_LDI:  iclass = CL_MEM_LDI;
            OP_ST:   iclass = CL_MEM_ST;
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                iclass = CL_ALU_R;
                alu_op = opcode;
            end
            OP_ADDI: iclass = CL_ALU_I;
            OP_ANDI: begin
                iclass = CL_ALU_I;
                alu_op = ALU_AND;
            end
            OP_ORI: begin
                iclass = CL_ALU_I;
                alu_op = ALU_OR;
            end
            OP_NOP:  iclass = CL_NOP;
            OP_HALT: iclass = CL_HALT;
            default: iclass = CL_ILL;
        endcase
    end

endmodule

// File: rtl/datapath_ctrl.sv
// Hardwired Moore controller for the single-bus datapath: fetch F0-F2, execute
// E3-E7, run/stop handling and a saturating retired-instruction counter.
module datapath_ctrl
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [31:0]      ir,
    input  logic             stop,
    output logic             PCout,
    output logic             PCin,
    output logic             IncPC,
    output logic             MARin,
    output logic             MDRin,
    output logic             MDRout,
    output logic             Read,
    output logic             IRin,
    output logic             Yin,
    output logic             ZLOin,
    output logic             ZLOout,
    output logic             Gra,
    output logic             Grb,
    output logic             Grc,
    output logic             Rin,
    output logic             Rout,
    output logic             BAout,
    output logic             Cout,
    output logic             RAM_write,
    output logic [4:0]       ALU_opcode,
    output logic             run,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    state_t     state, state_nxt;
    iclass_t    iclass;
    logic [4:0] dec_alu;
    ctrl_t      ctl;
    logic       retire;

    // Register fields are routed by Gra/Grb/Grc in the datapath, not here.
    logic unused_ir;
    assign unused_ir = ^ir[26:0];

    ctrl_decode u_decode (
        .opcode (ir[31:27]),
        .iclass (iclass),
        .alu_op (dec_alu)
    );

    always_ff @(posedge clk or posedge clr) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (clr) begin
            state       <= ST_RST;
            instr_count <= '0;
        end else begin
            state <= state_nxt;
            if (retire && instr_count != {CNT_W{1'b1}})
                instr_count <= instr_count + 1'b1;
        end
    end

    always_comb begin
        state_nxt  = state;
        ctl        = '0;
        ALU_opcode = 5'd0;
        illegal    = 1'b0;
        retire     = 1'b0;
        case (state)
            ST_RST: state_nxt = ST_F0;
            ST_F0: begin
                ctl.pc_out = 1'b1; ctl.mar_in = 1'b1; ctl.inc_pc = 1'b1; ctl.zlo_in = 1'b1;
                state_nxt  = ST_F1;
            end
            ST_F1: begin
                ctl.zlo_out = 1'b1; ctl.pc_in = 1'b1; ctl.read = 1'b1; ctl.mdr_in = 1'b1;
                state_nxt   = ST_F2;
            end
            ST_F2: begin
                ctl.mdr_out = 1'b1; ctl.ir_in = 1'b1;
                state_nxt   = ST_E3;
            end
            ST_E3: begin
                case (iclass)
                    CL_MEM_LD, CL_MEM_LDI, CL_MEM_ST: begin
                        ctl.grb = 1'b1; ctl.ba_out = 1'b1; ctl.y_in = 1'b1;
                        state_nxt = ST_E4;
                    end
                    CL_ALU_R, CL_ALU_I: begin
                        ctl.grb = 1'b1; ctl.r_out = 1'b1; ctl.y_in = 1'b1;
                        state_nxt = ST_E4;
                    end
                    CL_NOP: begin
                        retire    = 1'b1;
                        state_nxt = stop ? ST_HALT : ST_F0;
                    end
                    CL_HALT: begin
                        retire    = 1'b1;
                        state_nxt = ST_HALT;
                    end
                    default: begin
                        illegal   = 1'b1;
                        state_nxt = ST_F0;
                    end
                endcase
            end
            ST_E4: begin
                // R-type takes its second operand from Rc; everything else uses C.
                if (iclass == CL_ALU_R) begin
                    ctl.grc = 1'b1; ctl.r_out = 1'b1;
                end else begin
                    ctl.c_out = 1'b1;
                end
                ctl.zlo_in = 1'b1;
                ALU_opcode = dec_alu;
                state_nxt  = ST_E5;
            end
            ST_E5: begin
                ctl.zlo_out = 1'b1;
                if (iclass == CL_MEM_LD || iclass == CL_MEM_ST) begin
                    ctl.mar_in = 1'b1;
                    state_nxt  = ST_E6;
                end else begin
                    ctl.gra = 1'b1; ctl.r_in = 1'b1;
                    retire    = 1'b1;
                    state_nxt = stop ? ST_HALT : ST_F0;
                end
            end
            ST_E6: begin
                if (iclass == CL_MEM_ST) begin
                    ctl.gra = 1'b1; ctl.r_out = 1'b1;
                end else begin
                    ctl.read = 1'b1;
                end
                ctl.mdr_in = 1'b1;
                state_nxt  = ST_E7;
            end
            ST_E7: begin
                if (iclass == CL_MEM_ST) begin
                    ctl.ram_write = 1'b1;
                end else begin
                    ctl.mdr_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1;
                end
                retire    = 1'b1;
                state_nxt = stop ? ST_HALT : ST_F0;
            end
            ST_HALT: state_nxt = ST_HALT;
            default: state_nxt = ST_RST;
        endcase
    end

    assign run = (state != ST_RST) && (state != ST_HALT);

    assign {PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin, Yin, ZLOin, ZLOout,
            Gra, Grb, Grc, Rin, Rout, BAout, Cout, RAM_write} = ctl;

endmodule

// File: tb/tb_datapath_ctrl.sv
// Scoreboard bench for datapath_ctrl: per-cycle expected control vectors are
// queued when an instruction is issued and compared on the falling edge.
module tb_datapath_ctrl;

    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          clr = 1'b0;
    logic          stop = 1'b0;
    logic [31:0]   ir = 32'd0;
    logic          PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin, Yin, ZLOin, ZLOout;
    logic          Gra, Grb, Grc, Rin, Rout, BAout, Cout, RAM_write;
    logic [4:0]    ALU_opcode;
    logic          run, illegal;
    logic [CW-1:0] instr_count;

    datapath_ctrl #(.CNT_W(CW)) dut (
        .clk         (clk),
        .clr         (clr),
        .ir          (ir),
        .stop        (stop),
        .PCout       (PCout),
        .PCin        (PCin),
        .IncPC       (IncPC),
        .MARin       (MARin),
        .MDRin       (MDRin),
        .MDRout      (MDRout),
        .Read        (Read),
        .IRin        (IRin),
        .Yin         (Yin),
        .ZLOin       (ZLOin),
        .ZLOout      (ZLOout),
        .Gra         (Gra),
        .Grb         (Grb),
        .Grc         (Grc),
        .Rin         (Rin),
        .Rout        (Rout),
        .BAout       (BAout),
        .Cout        (Cout),
        .RAM_write   (RAM_write),
        .ALU_opcode  (ALU_opcode),
        .run         (run),
        .illegal     (illegal),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    logic [25:0] obs;
    assign obs = {PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin, Yin, ZLOin, ZLOout,
                  Gra, Grb, Grc, Rin, Rout, BAout, Cout, RAM_write, ALU_opcode, run, illegal};

    localparam logic [18:0] M_PCOUT  = 19'd1 << 18;
    localparam logic [18:0] M_PCIN   = 19'd1 << 17;
    localparam logic [18:0] M_INCPC  = 19'd1 << 16;
    localparam logic [18:0] M_MARIN  = 19'd1 << 15;
    localparam logic [18:0] M_MDRIN  = 19'd1 << 14;
    localparam logic [18:0] M_MDROUT = 19'd1 << 13;
    localparam logic [18:0] M_READ   = 19'd1 << 12;
    localparam logic [18:0] M_IRIN   = 19'd1 << 11;
    localparam logic [18:0] M_YIN    = 19'd1 << 10;
    localparam logic [18:0] M_ZLOIN  = 19'd1 << 9;
    localparam logic [18:0] M_ZLOOUT = 19'd1 << 8;
    localparam logic [18:0] M_GRA    = 19'd1 << 7;
    localparam logic [18:0] M_GRB    = 19'd1 << 6;
    localparam logic [18:0] M_GRC    = 19'd1 << 5;
    localparam logic [18:0] M_RIN    = 19'd1 << 4;
    localparam logic [18:0] M_ROUT   = 19'd1 << 3;
    localparam logic [18:0] M_BAOUT  = 19'd1 << 2;
    localparam logic [18:0] M_COUT   = 19'd1 << 1;
    localparam logic [18:0] M_RAMW   = 19'd1;

    typedef struct packed {
        logic [25:0]   vec;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t          sb[$];
    logic [CW-1:0] exp_count = '0;
    int            n_tests = 0;
    int            n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_run(input logic [18:0] c, input logic [4:0] alu, input logic ill);
        exp_t e;
        e.vec = {c, alu, 1'b1, ill};
        e.cnt = exp_count;
        sb.push_back(e);
    endtask

    task automatic push_idle(input int n);
        exp_t e;
        e.vec = '0;
        e.cnt = exp_count;
        for (int i = 0; i < n; i++) sb.push_back(e);
    endtask

    // Reference sequence for one instruction, straight from the step tables.
    task automatic push_instr(input logic [31:0] instr);
        logic [4:0] op;
        logic       ret;
        op  = instr[31:27];
        ret = 1'b1;
        push_run(M_PCOUT | M_MARIN | M_INCPC | M_ZLOIN, 5'd0, 1'b0);
        push_run(M_ZLOOUT | M_PCIN | M_READ | M_MDRIN, 5'd0, 1'b0);
        push_run(M_MDROUT | M_IRIN, 5'd0, 1'b0);
        case (op)
            5'b00000, 5'b00001, 5'b00010: begin
                push_run(M_GRB | M_BAOUT | M_YIN, 5'd0, 1'b0);
                push_run(M_COUT | M_ZLOIN, 5'b00011, 1'b0);
                if (op == 5'b00001) begin
                    push_run(M_ZLOOUT | M_GRA | M_RIN, 5'd0, 1'b0);
                end else begin
                    push_run(M_ZLOOUT | M_MARIN, 5'd0, 1'b0);
                    if (op == 5'b00000) begin
                        push_run(M_READ | M_MDRIN, 5'd0, 1'b0);
                        push_run(M_MDROUT | M_GRA | M_RIN, 5'd0, 1'b0);
                    end else begin
                        push_run(M_GRA | M_ROUT | M_MDRIN, 5'd0, 1'b0);
                        push_run(M_RAMW, 5'd0, 1'b0);
                    end
                end
            end
            5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
                push_run(M_GRB | M_ROUT | M_YIN, 5'd0, 1'b0);
                push_run(M_GRC | M_ROUT | M_ZLOIN, op, 1'b0);
                push_run(M_ZLOOUT | M_GRA | M_RIN, 5'd0, 1'b0);
            end
            5'b01100, 5'b01101, 5'b01110: begin
                push_run(M_GRB | M_ROUT | M_YIN, 5'd0, 1'b0);
                push_run(M_COUT | M_ZLOIN,
                         (op == 5'b01100) ? 5'b00011 : (op == 5'b01101) ? 5'b00101 : 5'b00110,
                         1'b0);
                push_run(M_ZLOOUT | M_GRA | M_RIN, 5'd0, 1'b0);
            end
            5'b11010, 5'b11011: push_run(19'd0, 5'd0, 1'b0);
            default: begin
                push_run(19'd0, 5'd0, 1'b1);
                ret = 1'b0;
            end
        endcase
        if (ret && exp_count != {CW{1'b1}}) exp_count = exp_count + 1'b1;
    endtask

    task automatic check_cycle(input string tag);
        exp_t e;
        @(negedge clk);
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard underrun at t=%0t", tag, $time);
        end else begin
            e = sb.pop_front();
            check({tag, "_ctl"}, {6'd0, obs}, {6'd0, e.vec});
            check({tag, "_cnt"}, {29'd0, instr_count}, {29'd0, e.cnt});
        end
    endtask

    task automatic drain(input string tag);
        while (sb.size() > 0) check_cycle(tag);
    endtask

    // ir is presented after the F0 check and held until the instruction retires.
    task automatic run_instr(input logic [31:0] instr, input int halt_cycles, input string tag);
        push_instr(instr);
        push_idle(halt_cycles);
        check_cycle(tag);
        ir = instr;
        drain(tag);
    endtask

    task automatic do_reset(input string tag);
        clr = 1'b1;
        #1;
        check({tag, "_ctl"}, {6'd0, obs}, 32'd0);
        check({tag, "_cnt"}, {29'd0, instr_count}, 32'd0);
        sb.delete();
        exp_count = '0;
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        do_reset("reset");

        run_instr(32'h0090_0054, 0, "ld");
        run_instr(32'h1108_0087, 0, "st");
        run_instr(32'h1A92_0000, 0, "add");
        run_instr(32'hF800_0000, 0, "illegal");
        run_instr(32'h2000_0000, 0, "sub");
        run_instr(32'h2800_0000, 0, "and");
        run_instr(32'h3000_0000, 0, "or");
        run_instr(32'h0800_0000, 0, "ldi");
        run_instr(32'h6000_0000, 0, "addi");
        run_instr(32'h6800_0000, 0, "andi");
        run_instr(32'h7000_0000, 0, "ori");
        run_instr(32'hD000_0000, 0, "nop");

        // halt, with stop toggled while halted to show it is ignored
        push_instr(32'hD800_0000);
        push_idle(20);
        check_cycle("halt");
        ir = 32'hD800_0000;
        for (int i = 0; i < 3; i++) check_cycle("halt");
        stop = 1'b1;
        for (int i = 0; i < 10; i++) check_cycle("halt_idle");
        stop = 1'b0;
        drain("halt_idle");

        do_reset("clr_in_halt");

        // stop raised during E4 of ld: instruction completes, then HALT
        push_instr(32'h0090_0054);
        push_idle(3);
        check_cycle("ld_stop");
        ir = 32'h0090_0054;
        for (int i = 0; i < 4; i++) check_cycle("ld_stop");
        stop = 1'b1;
        drain("ld_stop");
        stop = 1'b0;

        // stop and halt together: one increment, then HALT
        do_reset("clr2");
        stop = 1'b1;
        run_instr(32'hD800_0000, 3, "halt_stop");
        stop = 1'b0;

        // clr in E5 of ld forces everything low without waiting for a clock
        do_reset("clr3");
        push_instr(32'h0090_0054);
        check_cycle("ld_abort");
        ir = 32'h0090_0054;
        for (int i = 0; i < 5; i++) check_cycle("ld_abort");
        do_reset("clr_e5");

        run_instr(32'h1A92_0000, 0, "add_after_abort");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
